// File: rtl/booth_mult_sequencer.sv
// Sequential radix-4 Booth multiplier: one 18-bit partial product per cycle,
// accumulated shifted into an ACC_W-bit signed result, with valid/ready on both sides.
module booth_mult_sequencer #(
    parameter int unsigned EARLY_TERM = 1,
    parameter int unsigned ACC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      md,
    input  logic [15:0]      mr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] product,
    output logic [3:0]       digits_used,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       md_q, md_d, mr_q, mr_d;
    logic [ACC_W-1:0]  acc_q, acc_d, product_q, product_d;
    logic [2:0]        k_q, k_d;
    logic [3:0]        n_q, n_d, digits_q, digits_d;

    // Smallest n such that mr[15:2n-1] is a pure sign run; digits beyond it are all zero.
    function automatic logic [3:0] term_digits(input logic [15:0] m);
        logic [3:0]  n;
        logic [15:0] t;
        n = 4'd8;
        for (int i = 8; i >= 1; i--) begin
            t = $signed(m) >>> (2 * i - 1);
            if (t == '0 || t == '1) n = 4'(i);
        end
        return n;
    endfunction

    logic [16:0]        mrx;
    logic [2:0]         trip;
    logic signed [17:0] md_x, pp;
    logic [ACC_W-1:0]   pp_ext, acc_add;

    assign mrx    = {mr_q, 1'b0};
    assign trip   = mrx[{k_q, 1'b0} +: 3];
    assign md_x   = {{2{md_q[15]}}, md_q};
    assign pp_ext = {{(ACC_W-18){pp[17]}}, pp};
    assign acc_add = acc_q + (pp_ext << {k_q, 1'b0});

    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = md_x;
            3'b011:         pp = md_x <<< 1;
            3'b100:         pp = -(md_x <<< 1);
            3'b101, 3'b110: pp = -md_x;
            default:        pp = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        md_d      = md_q;
        mr_d      = mr_q;
        acc_d     = acc_q;
        k_d       = k_q;
        n_d       = n_q;
        product_d = product_q;
        digits_d  = digits_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    md_d    = md;
                    mr_d    = mr;
                    acc_d   = '0;
                    k_d     = '0;
                    n_d     = (EARLY_TERM != 0) ? term_digits(mr) : 4'd8;
                    state_d = RUN;
                end
                RUN: begin
                    acc_d = acc_add;
                    k_d   = k_q + 3'd1;
                    if ({1'b0, k_q} == n_q - 4'd1) begin
                        state_d   = DONE;
                        product_d = acc_add;
                        digits_d  = n_q;
                    end
                end
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            md_q      <= '0;
            mr_q      <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            n_q       <= '0;
            product_q <= '0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            md_q      <= md_d;
            mr_q      <= mr_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            n_q       <= n_d;
            product_q <= product_d;
            digits_q  <= digits_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign product     = product_q;
    assign digits_used = digits_q;

endmodule
